map_access_arbiter: RTL

//  Shares the single-port game-map RAM between all movers (req 0 = pacman, 1..N-1 = ghosts).

---
 rtl/map_access_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/map_access_arbiter.sv
// Round-robin arbiter sharing the single-port map RAM between pacman and ghosts.
// Each grant runs read-destination, erase-source, write-destination, then pulses done.
module map_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 6,
  parameter int Y_W     = 5,
  parameter int TILE_W  = 4,
  parameter int RAM_LAT = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*X_W-1:0]    curr_x,
  input  logic [NUM_REQ*Y_W-1:0]    curr_y,
  input  logic [NUM_REQ*X_W-1:0]    next_x,
  input  logic [NUM_REQ*Y_W-1:0]    next_y,
  input  logic [NUM_REQ*TILE_W-1:0] sprite,
  input  logic [NUM_REQ*TILE_W-1:0] erase_tile,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        done,
  output logic [TILE_W-1:0]         collision_type,
  output logic                      pill_eaten,
  output logic [Y_W+X_W-1:0]        ram_addr,
  output logic                      ram_wren,
  output logic [TILE_W-1:0]         ram_wdata,
  input  logic [TILE_W-1:0]         ram_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [TILE_W-1:0] T_WALL = TILE_W'(1);
  localparam logic [TILE_W-1:0] T_PILL = TILE_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_ERASE, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gi_q, gi_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  mask_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [X_W-1:0]      cx_q, cx_d, nx_q, nx_d;
  logic [Y_W-1:0]      cy_q, cy_d, ny_q, ny_d;
  logic [TILE_W-1:0]   spr_q, spr_d, ers_q, ers_d;
  logic [TILE_W-1:0]   col_q, col_d;

  logic                hit;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       jj;
  int                  j;

  // first eligible requester at/after the pointer, wrapping
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    jj   = '0;
    j    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!hit && req[jj] && !mask_q[jj]) begin
        hit  = 1'b1;
        pick = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gi_d    = gi_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    spr_d   = spr_q;
    ers_d   = ers_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hit) begin
          state_d = S_READ;
          gi_d    = pick;
          gnt_d   = NUM_REQ'(1) << pick;
          cx_d    = curr_x[int'(pick)*X_W +: X_W];
          cy_d    = curr_y[int'(pick)*Y_W +: Y_W];
          nx_d    = next_x[int'(pick)*X_W +: X_W];
          ny_d    = next_y[int'(pick)*Y_W +: Y_W];
          spr_d   = sprite[int'(pick)*TILE_W +: TILE_W];
          ers_d   = erase_tile[int'(pick)*TILE_W +: TILE_W];
        end
      end
      S_READ: begin
        if (cnt_q == CW'(RAM_LAT - 1)) state_d = S_CHECK;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        col_d = ram_rdata;
        if (ram_rdata == T_WALL)                  state_d = S_DONE;
        else if (cx_q == nx_q && cy_q == ny_q)    state_d = S_WRITE;
        else                                      state_d = S_ERASE;
      end
      S_ERASE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        rr_d    = (int'(gi_q) == NUM_REQ - 1) ? '0 : IW'(gi_q + 1'b1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      S_READ:  ram_addr = {ny_q, nx_q};
      S_ERASE: begin
        ram_addr  = {cy_q, cx_q};
        ram_wdata = ers_q;
        ram_wren  = 1'b1;
      end
      S_WRITE: begin
        ram_addr  = {ny_q, nx_q};
        ram_wdata = spr_q;
        ram_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant          = gnt_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE) ? gnt_q : '0;
  assign collision_type = col_q;
  assign pill_eaten     = (state_q == S_DONE) && (gi_q == '0)
                          && (col_q == T_PILL);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gi_q    <= '0;
      gnt_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      spr_q   <= '0;
      ers_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gi_q    <= gi_d;
      gnt_q   <= gnt_d;
      mask_q  <= done;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      spr_q   <= spr_d;
      ers_q   <= ers_d;
      col_q   <= col_d;
    end
  end

endmodule
